// File: rtl/sc_inst_enc_if.sv
// ============================================================================
// Module   : sc_inst_enc_if
// Brief    : Handshake, memory-write and status bundle for sc_inst_enc.
//            Optional csum member under SC_INST_ENC_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sc_inst_enc_if #(
  parameter int AW = 32
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_code;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_sa;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_din;
  logic          imem_ack;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   word_cnt;
`ifdef SC_INST_ENC_CHECKSUM_EN
  logic [31:0]   csum;

  modport master (
    output start, base_addr, in_valid, in_code, in_rs, in_rt, in_rd, in_sa,
           in_imm, in_target, in_last, imem_ack,
    input  in_ready, imem_we, imem_addr, imem_din, busy, done, err, word_cnt, csum
  );
  modport slave (
    input  start, base_addr, in_valid, in_code, in_rs, in_rt, in_rd, in_sa,
           in_imm, in_target, in_last, imem_ack,
    output in_ready, imem_we, imem_addr, imem_din, busy, done, err, word_cnt, csum
  );
`else
  modport master (
    output start, base_addr, in_valid, in_code, in_rs, in_rt, in_rd, in_sa,
           in_imm, in_target, in_last, imem_ack,
    input  in_ready, imem_we, imem_addr, imem_din, busy, done, err, word_cnt
  );
  modport slave (
    input  start, base_addr, in_valid, in_code, in_rs, in_rt, in_rd, in_sa,
           in_imm, in_target, in_last, imem_ack,
    output in_ready, imem_we, imem_addr, imem_din, busy, done, err, word_cnt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/sc_inst_enc.sv
// ============================================================================
// Module   : sc_inst_enc
// Brief    : Packs symbolic instructions into MIPS words and loads them into
//            instruction memory. SC_INST_ENC_CHECKSUM_EN adds an XOR checksum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sc_inst_enc #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] BASE_RST = '0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  sc_inst_enc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_din;
  logic          r_we;
  logic          r_err;
  logic [15:0]   r_cnt;

  logic          w_ready;
  logic          w_busy;
  logic          w_done;
  logic          w_start;
  logic          w_accept;
  logic          w_ack;
  logic          w_legal;
  logic [31:0]   w_word;
  logic [AW-1:0] w_base;

  assign w_base   = bus.base_addr & ~AW'(3);
  assign w_ack    = r_we & bus.imem_ack;
  assign w_accept = bus.in_valid & w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = bus.start;
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_busy  = 1'b1;
        w_ready = ~r_we | bus.imem_ack;
        if (bus.in_valid && w_ready && bus.in_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (!r_we || bus.imem_ack) w_next = S_FIN;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Field packing; fields that the format defines as zero are forced to zero.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (bus.in_code)
      5'd0:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100000};
      5'd1:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100010};
      5'd2:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100100};
      5'd3:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100101};
      5'd4:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100110};
      5'd5:  w_word = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'b000000};
      5'd6:  w_word = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'b000010};
      5'd7:  w_word = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'b000011};
      5'd8:  w_word = {6'b000000, bus.in_rs, 15'd0, 6'b001000};
      5'd9:  w_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd10: w_word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd11: w_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd12: w_word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd13: w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd14: w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd15: w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd16: w_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
      5'd17: w_word = {6'b001111, 5'd0, bus.in_rt, bus.in_imm};
      5'd18: w_word = {6'b000010, bus.in_target};
      5'd19: w_word = {6'b000011, bus.in_target};
      default: w_legal = 1'b0;
    endcase
  end

  // An accept while a write is pending only happens on its ack cycle, so the
  // new word (or nothing, if illegal) simply replaces the outgoing one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr <= BASE_RST;
      r_din     <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_start) begin
        r_wr_addr <= w_base;
        r_err     <= 1'b0;
        r_cnt     <= '0;
      end else if (w_ack) begin
        r_wr_addr <= r_wr_addr + AW'(4);
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
      if (w_accept) begin
        r_we <= w_legal;
        if (w_legal) r_din <= w_word;
        else         r_err <= 1'b1;
      end else if (w_ack) begin
        r_we <= 1'b0;
      end
    end
  end

`ifdef SC_INST_ENC_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_ack)   r_csum <= r_csum ^ r_din;
  end

  assign bus.csum = r_csum;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.imem_we   = r_we;
  assign bus.imem_addr = r_wr_addr;
  assign bus.imem_din  = r_din;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = r_err;
  assign bus.word_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sc_inst_enc.sv
// ============================================================================
// Module   : tb_sc_inst_enc
// Brief    : Directed self-checking bench for sc_inst_enc.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sc_inst_enc;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sc_inst_enc_if #(.AW(32)) bus ();

  sc_inst_enc #(
    .AW       (32),
    .BASE_RST (32'h0000_0040)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] code, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last);
    bus.in_valid  = 1'b1;
    bus.in_code   = code;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_sa     = sa;
    bus.in_imm    = imm;
    bus.in_target = tgt;
    bus.in_last   = last;
  endtask

  task automatic do_start(input logic [31:0] a);
    bus.start     = 1'b1;
    bus.base_addr = a;
    tick();
    bus.start     = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.imem_ack = 1'b0;
    bus.in_valid = 1'b0; bus.in_code = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_sa = '0; bus.in_imm = '0; bus.in_target = '0; bus.in_last = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_we",    bus.imem_we, 0);
    chk("rst_din",   bus.imem_din, 0);
    chk("rst_addr",  bus.imem_addr, 32'h40);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_err",   bus.err, 0);
    chk("rst_cnt",   bus.word_cnt, 0);
    rst = 1'b0;
    tick();

    // single add, acked right away
    do_start(32'h100);
    chk("t1_busy", bus.busy, 1);
    chk("t1_ready", bus.in_ready, 1);
    drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_we", bus.imem_we, 1);
    chk("t1_addr", bus.imem_addr, 32'h100);
    chk("t1_din", bus.imem_din, 32'h0022_1820);
    chk("t1_drain_ready", bus.in_ready, 0);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("t1_done", bus.done, 1);
    chk("t1_busy_fin", bus.busy, 0);
    chk("t1_cnt", bus.word_cnt, 1);
    chk("t1_we_off", bus.imem_we, 0);
    chk("t1_addr_next", bus.imem_addr, 32'h104);
    tick();
    chk("t1_done_once", bus.done, 0);

    // streaming with ack held high
    bus.imem_ack = 1'b1;
    do_start(32'h0);
    drive(5'd9, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    #1 chk("t2_ready0", bus.in_ready, 1);
    tick();
    chk("t2_din0", bus.imem_din, 32'h2008_FFFF);
    chk("t2_addr0", bus.imem_addr, 32'h0);
    drive(5'd13, 5'd8, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
    #1 chk("t2_ready1", bus.in_ready, 1);
    tick();
    chk("t2_din1", bus.imem_din, 32'h8D09_0004);
    chk("t2_addr1", bus.imem_addr, 32'h4);
    drive(5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0040, 1'b1);
    #1 chk("t2_ready2", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_din2", bus.imem_din, 32'h0800_0040);
    chk("t2_addr2", bus.imem_addr, 32'h8);
    chk("t2_we2", bus.imem_we, 1);
    tick();
    chk("t2_done", bus.done, 1);
    chk("t2_cnt", bus.word_cnt, 3);
    chk("t2_addr_end", bus.imem_addr, 32'hC);
`ifdef SC_INST_ENC_CHECKSUM_EN
    chk("t2_csum", bus.csum, 32'hA501_FFBB);
`endif
    bus.imem_ack = 1'b0;
    tick();

    // stalled write; start while busy must be ignored
    do_start(32'h200);
    drive(5'd1, 5'd4, 5'd5, 5'd6, 5'd9, 16'h0, 26'h0, 1'b0);
    tick();
    drive(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.start     = (i == 2);
      bus.base_addr = 32'h900;
      #1;
      chk("t3_we", bus.imem_we, 1);
      chk("t3_addr", bus.imem_addr, 32'h200);
      chk("t3_din", bus.imem_din, 32'h0085_3022);
      chk("t3_ready", bus.in_ready, 0);
      tick();
    end
    bus.start    = 1'b0;
    bus.imem_ack = 1'b1;
    #1 chk("t3_ready_ack", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("t3_din_next", bus.imem_din, 32'h1022_FFFE);
    chk("t3_addr_next", bus.imem_addr, 32'h204);
    chk("t3_cnt_mid", bus.word_cnt, 1);
    tick();
    chk("t3_done", bus.done, 1);
    chk("t3_cnt", bus.word_cnt, 2);
    bus.imem_ack = 1'b0;
    tick();

    // encodings with forced-zero fields
    bus.imem_ack = 1'b1;
    do_start(32'h300);
    drive(5'd5, 5'd31, 5'd4, 5'd5, 5'd2, 16'h0, 26'h0, 1'b0);
    tick();
    chk("t4_sll", bus.imem_din, 32'h0004_2880);
    drive(5'd8, 5'd31, 5'd7, 5'd9, 5'd3, 16'h0, 26'h0, 1'b0);
    tick();
    chk("t4_jr", bus.imem_din, 32'h03E0_0008);
    chk("t4_jr_addr", bus.imem_addr, 32'h304);
    drive(5'd17, 5'd7, 5'd3, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    tick();
    chk("t4_lui", bus.imem_din, 32'h3C03_1234);
    drive(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b0);
    tick();
    chk("t4_jal", bus.imem_din, 32'h0FFF_FFFF);
    drive(5'd14, 5'd29, 5'd2, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0);
    tick();
    chk("t4_sw", bus.imem_din, 32'hAFA2_0008);
    drive(5'd7, 5'd5, 5'd2, 5'd1, 5'd31, 16'h0, 26'h0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_sra", bus.imem_din, 32'h0002_0FC3);
    chk("t4_sra_addr", bus.imem_addr, 32'h314);
    tick();
    chk("t4_done", bus.done, 1);
    chk("t4_cnt", bus.word_cnt, 6);
    bus.imem_ack = 1'b0;
    tick();

    // illegal code mid-stream
    bus.imem_ack = 1'b1;
    do_start(32'h400);
    drive(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk("t5_or", bus.imem_din, 32'h0022_1825);
    drive(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
    tick();
    chk("t5_ill_we", bus.imem_we, 0);
    chk("t5_ill_err", bus.err, 1);
    chk("t5_ill_addr", bus.imem_addr, 32'h404);
    chk("t5_ill_cnt", bus.word_cnt, 1);
    drive(5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t5_xori", bus.imem_din, 32'h3822_00FF);
    chk("t5_xori_addr", bus.imem_addr, 32'h404);
    tick();
    chk("t5_done", bus.done, 1);
    chk("t5_cnt", bus.word_cnt, 2);
    bus.imem_ack = 1'b0;
    tick();
    chk("t5_err_sticky", bus.err, 1);

    // address wrap, then reset during a stalled write
    do_start(32'hFFFF_FFFF);
    chk("t6_err_clr", bus.err, 0);
    chk("t6_cnt_clr", bus.word_cnt, 0);
    chk("t6_base", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_ack = 1'b1;
    drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk("t6_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    drive(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    chk("t6_wrap", bus.imem_addr, 32'h0);
    chk("t6_and", bus.imem_din, 32'h0022_1824);
    bus.imem_ack = 1'b0;
    drive(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    repeat (3) tick();
    chk("t6_stall_we", bus.imem_we, 1);
    chk("t6_stall_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", bus.imem_we, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_ready", bus.in_ready, 0);
    chk("t6_rst_addr", bus.imem_addr, 32'h40);
    chk("t6_rst_cnt", bus.word_cnt, 0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
